newton_multiply: RTL and testbench
==================================

// Module: newton_multiply
// PURPOSE
//  Final stage of the fast inverse square root Newton-Raphson step: y1 = y0 * (1.5 - 0.5*x*y0^2).
//  Consumes the subtraction stage outputs (NumOut = 1.5 - 0.5*x*y0^2, Init_data = y0) and forms their
//  IEEE-754 single-precision product in a 3-stage pipeline. Carries a valid bit and a user tag alongside the data.
//  Output feeds the next iteration or the top-level result register.
// PARAMETERS
//  EXP_BIAS  127  exponent bias subtracted from the sum of the two operand exponents
//  TAG_W     4    width of sideband tag carried alongside the data with matching latency
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  ce         in   1       pipeline advance enable; 0 = every register holds
//  in_valid   in   1       NumA/Init/in_tag are valid this cycle (sampled only when ce=1)
//  NumA       in   32      multiplicand, IEEE-754 single (from subtraction stage NumOut)
//  Init       in   32      multiplier, IEEE-754 single (y0, from subtraction stage Init_data)
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       Result/out_tag valid
//  Result     out  32      product, IEEE-754 single
//  out_tag    out  TAG_W   tag delayed to match Result
// BEHAVIOUR
//  - Reset: out_valid=0, Result=0, out_tag=0, all internal valid bits=0, all data registers=0.
//  - Reset wins over ce: rst=1 clears the pipeline even when ce=0. Reset mid-operation drops in-flight data;
//    no out_valid may appear for samples accepted before reset.
//  - ce=1: one sample in, pipeline shifts one stage. ce=0: all registers (data, valid, tag) hold; no bubble inserted.
//  - Latency: 3 ce-enabled cycles from input sample to Result/out_valid. Throughput 1 per ce cycle.
//  - Data registers advance on every ce=1 cycle regardless of valid; only out_valid qualifies Result.
//  - Stage 1 (unpack): sign = NumA[31]^Init[31]; ma = {1,NumA[22:0]}, mb = {1,Init[22:0]};
//    esum = NumA[30:23] + Init[30:23] - EXP_BIAS in 10-bit signed; zero = (NumA[30:23]==0)|(Init[30:23]==0).
//  - Stage 2 (multiply): p = ma*mb, 48 bits unsigned; sign, esum, zero, valid, tag forwarded.
//  - Stage 3 (normalise/pack):
//      p[47]=1 -> frac = p[46:24], e = esum+1;  else frac = p[45:23], e = esum.
//      Rounding: truncate (no round-to-nearest).
//      zero flag or e <= 0  -> Result = {sign, 31'b0}   (denormals flushed to signed zero).
//      e >= 255             -> Result = {sign, 8'hFF, 23'b0} (saturate to signed infinity).
//      else                 -> Result = {sign, e[7:0], frac}.
//  - Inputs with exponent 0 are treated as zero (denormals not supported); exponent 255 inputs (Inf/NaN)
//    are not special-cased and follow the arithmetic path (documented limitation).
//  - No backpressure beyond ce; downstream must consume when out_valid=1 and ce=1.
// STRUCTURE
//  - Shared package (fisr_pkg): FP32 field widths (EXP_W=8, FRAC_W=23), EXP_BIAS=127, constants
//    FP_ONE_HALF=32'h3FC00000, FP_POS_INF=32'h7F800000, fp32 unpacked struct {sign, exp, frac}.
//  - One natural sub-module: fp32_normalize_pack (stage-3 combinational normalise/saturate/pack),
//    reusable by the upstream multiply stages. Pipeline registers stay in newton_multiply.
// TESTING
//  - NumA=32'h3FC00000 (1.5), Init=32'h3F800000 (1.0), in_valid=1, ce=1 -> 3 cycles later out_valid=1, Result=32'h3FC00000.
//  - 1.5*1.5 (32'h3FC00000 x2) -> Result=32'h40100000 (2.25, p[47] normalise path); -1.0*2.0 -> 32'hC0000000.
//  - NumA=0, Init=32'h40490FDB -> Result=0; 32'h00800000*32'h00800000 -> 0 (underflow flush);
//    32'h7F000000*32'h7F000000 -> 32'h7F800000 (overflow saturate).
//  - Back-to-back 8 samples with tags 0..7, ce=1 -> 8 consecutive out_valid, results/tags in order, latency 3.
//  - ce=0 for 2 cycles while 3 samples in flight -> Result/out_valid/out_tag frozen; resume completes with latency 3+2.
//  - rst=1 for 1 cycle with 2 samples in flight (ce=0 and ce=1 variants) -> out_valid=0, Result=0 next cycle; no stale outputs.

Source files
------------

// File: rtl/fisr_pkg.sv
// Shared FP32 definitions for the fast inverse square root datapath.
package fisr_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned ESUM_W   = 10;
    localparam int          EXP_BIAS = 127;

    localparam logic [31:0] FP_ONE_HALF = 32'h3FC00000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Outcome of the exponent range check when packing a product.
    typedef enum logic [1:0] {
        PACK_NORMAL,
        PACK_ZERO,
        PACK_INF
    } pack_kind_e;

endpackage

// File: rtl/newton_multiply_if.sv
// Operand/result bundle of the Newton-Raphson multiply stage.
interface newton_multiply_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic [31:0]      NumA;
    logic [31:0]      Init;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic [31:0]      Result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, NumA, Init, in_tag,
        input  out_valid, Result, out_tag
    );

    modport slave (
        input  in_valid, NumA, Init, in_tag,
        output out_valid, Result, out_tag
    );
endinterface

// File: rtl/fp32_normalize_pack.sv
// Normalises a mantissa product, flushes underflow to signed zero,
// saturates overflow to signed infinity and packs an FP32 word.
module fp32_normalize_pack
    import fisr_pkg::*;
(
    input  logic                     sign,
    input  logic signed [ESUM_W-1:0] esum,
    input  logic                     zero,
    // Product bits [47:23]; lower bits never reach the result under truncation.
    input  logic [24:0]              p_hi,
    output logic [31:0]              result
);

    logic signed [ESUM_W-1:0] e;
    logic [FRAC_W-1:0]        frac;
    pack_kind_e               kind;
    fp32_t                    packed_val;

    // Select normalisation shift, classify exponent range and pack.
    always_comb begin
        e          = esum;
        frac       = p_hi[22:0];
        kind       = PACK_NORMAL;
        packed_val = '0;

        if (p_hi[24]) begin
            e    = esum + 10'sd1;
            frac = p_hi[23:1];
        end

        if (zero || (e <= 10'sd0)) begin
            kind = PACK_ZERO;
        end else if (e >= 10'sd255) begin
            kind = PACK_INF;
        end

        packed_val.sign = sign;
        unique case (kind)
            PACK_ZERO: begin
                packed_val.exp  = '0;
                packed_val.frac = '0;
            end
            PACK_INF: begin
                packed_val.exp  = FP_POS_INF[30:23];
                packed_val.frac = FP_POS_INF[22:0];
            end
            default: begin
                packed_val.exp  = e[7:0];
                packed_val.frac = frac;
            end
        endcase

        result = packed_val;
    end

endmodule

// File: rtl/newton_multiply.sv
// Newton-Raphson final stage: 3-stage FP32 multiply y1 = NumA * Init,
// with valid and tag carried alongside at matching latency.
module newton_multiply #(
    parameter int EXP_BIAS = fisr_pkg::EXP_BIAS,
    parameter int TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    newton_multiply_if.slave  bus
);
    import fisr_pkg::*;

    fp32_t                    a;
    fp32_t                    b;
    logic signed [ESUM_W-1:0] esum_next;
    logic [24:0]              p_hi_next;

    // Stage 1 registers (unpack)
    logic                     s1_valid;
    logic                     s1_sign;
    logic signed [ESUM_W-1:0] s1_esum;
    logic                     s1_zero;
    logic [23:0]              s1_ma;
    logic [23:0]              s1_mb;
    logic [TAG_W-1:0]         s1_tag;

    // Stage 2 registers (multiply)
    logic                     s2_valid;
    logic                     s2_sign;
    logic signed [ESUM_W-1:0] s2_esum;
    logic                     s2_zero;
    logic [24:0]              s2_p_hi;
    logic [TAG_W-1:0]         s2_tag;

    // Stage 3 registers (output)
    logic                     out_valid_q;
    logic [31:0]              result_q;
    logic [TAG_W-1:0]         out_tag_q;

    logic [31:0]              packed_result;

    assign a = bus.NumA;
    assign b = bus.Init;

    assign esum_next = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp})
                     - $signed(10'(EXP_BIAS));

    // Only product bits [47:23] are kept: truncation discards the rest
    // on both normalisation paths, so the result is unchanged.
    assign p_hi_next = 25'((48'(s1_ma) * 48'(s1_mb)) >> 23);

    fp32_normalize_pack u_pack (
        .sign   (s2_sign),
        .esum   (s2_esum),
        .zero   (s2_zero),
        .p_hi   (s2_p_hi),
        .result (packed_result)
    );

    // Pipeline registers: reset clears everything, ce=0 freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_esum     <= '0;
            s1_zero     <= 1'b0;
            s1_ma       <= '0;
            s1_mb       <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_esum     <= '0;
            s2_zero     <= 1'b0;
            s2_p_hi     <= '0;
            s2_tag      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else if (ce) begin
            s1_valid    <= bus.in_valid;
            s1_sign     <= a.sign ^ b.sign;
            s1_esum     <= esum_next;
            s1_zero     <= (a.exp == '0) || (b.exp == '0);
            s1_ma       <= {1'b1, a.frac};
            s1_mb       <= {1'b1, b.frac};
            s1_tag      <= bus.in_tag;

            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_esum     <= s1_esum;
            s2_zero     <= s1_zero;
            s2_p_hi     <= p_hi_next;
            s2_tag      <= s1_tag;

            out_valid_q <= s2_valid;
            result_q    <= packed_result;
            out_tag_q   <= s2_tag;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_newton_multiply.sv
// Directed-vector bench for newton_multiply: arithmetic table, streaming,
// ce stall and reset-flush sequences.
module tb_newton_multiply;

    logic clk;
    logic rst;
    logic ce;

    newton_multiply_if #(.TAG_W(4)) bus ();

    newton_multiply #(
        .EXP_BIAS (127),
        .TAG_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
        bus.in_valid = v;
        bus.NumA     = a;
        bus.Init     = b;
        bus.in_tag   = t;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_out(input string nm, input logic v, input logic [31:0] r,
                             input logic [3:0] t);
        check({nm, ".valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        if (v) begin
            check({nm, ".result"}, bus.Result, r);
            check({nm, ".tag"}, {28'b0, bus.out_tag}, {28'b0, t});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs.push_back('{"one_half_x_one",   32'h3FC00000, 32'h3F800000, 32'h3FC00000});
        vecs.push_back('{"sq_one_half",      32'h3FC00000, 32'h3FC00000, 32'h40100000});
        vecs.push_back('{"neg_one_x_two",    32'hBF800000, 32'h40000000, 32'hC0000000});
        vecs.push_back('{"two_x_three",      32'h40000000, 32'h40400000, 32'h40C00000});
        vecs.push_back('{"neg_x_neg",        32'hBFC00000, 32'hBFC00000, 32'h40100000});
        vecs.push_back('{"trunc_lo",         32'h3F800001, 32'h3F800001, 32'h3F800002});
        vecs.push_back('{"trunc_hi",         32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE});
        vecs.push_back('{"zero_x_pi",        32'h00000000, 32'h40490FDB, 32'h00000000});
        vecs.push_back('{"denorm_operand",   32'h3F800000, 32'h00400000, 32'h00000000});
        vecs.push_back('{"min_normal_kept",  32'h00800000, 32'h3F800000, 32'h00800000});
        vecs.push_back('{"underflow_e0",     32'h00800000, 32'h3F000000, 32'h00000000});
        vecs.push_back('{"underflow_neg",    32'h80800000, 32'h3F000000, 32'h80000000});
        vecs.push_back('{"underflow_deep",   32'h00800000, 32'h00800000, 32'h00000000});
        vecs.push_back('{"max_exp_kept",     32'h7F000000, 32'h3FC00000, 32'h7F400000});
        vecs.push_back('{"overflow",         32'h7F000000, 32'h7F000000, 32'h7F800000});
        vecs.push_back('{"overflow_norm",    32'h7F400000, 32'h3FC00000, 32'h7F800000});
        vecs.push_back('{"overflow_neg",     32'hFF000000, 32'h7F000000, 32'hFF800000});

        // Reset state
        rst = 1'b1;
        ce  = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
        step();
        check("reset.valid",  {31'b0, bus.out_valid}, 32'h0);
        check("reset.result", bus.Result, 32'h0);
        check("reset.tag",    {28'b0, bus.out_tag}, 32'h0);
        rst = 1'b0;

        // Isolated samples: not valid after 2 cycles, valid after 3
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].b, 4'(i));
            step();
            drive(1'b0, 32'h0, 32'h0, 4'h0);
            step();
            check({vecs[i].name, ".early"}, {31'b0, bus.out_valid}, 32'h0);
            step();
            check_out(vecs[i].name, 1'b1, vecs[i].exp, 4'(i));
        end

        // Back-to-back stream of 8 with tags 0..7
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive(1'b1, vecs[c].a, vecs[c].b, 4'(c));
            else       drive(1'b0, 32'h0, 32'h0, 4'h0);
            step();
            if (c >= 2 && c < 10)
                check_out($sformatf("stream%0d", c - 2), 1'b1, vecs[c-2].exp, 4'(c - 2));
            else
                check_out($sformatf("stream_idle%0d", c), 1'b0, 32'h0, 4'h0);
        end

        // ce stall with 3 samples in the pipe; inputs offered during the stall are ignored
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, vecs[c+1].a, vecs[c+1].b, 4'(c + 1));
            step();
        end
        check_out("stall_pre", 1'b1, vecs[1].exp, 4'd1);
        ce = 1'b0;
        drive(1'b1, 32'h40000000, 32'h40000000, 4'hF);
        for (int c = 0; c < 2; c++) begin
            step();
            check_out($sformatf("stall_hold%0d", c), 1'b1, vecs[1].exp, 4'd1);
        end
        ce = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
        check_out("stall_resume1", 1'b1, vecs[2].exp, 4'd2);
        step();
        check_out("stall_resume2", 1'b1, vecs[3].exp, 4'd3);
        step();
        check_out("stall_drain", 1'b0, 32'h0, 4'h0);

        // Reset flush with samples in flight: variant 0 with ce=1, variant 1 with ce=0
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, vecs[c+3].a, vecs[c+3].b, 4'(c + 8));
                step();
            end
            check_out($sformatf("rst%0d_pre", v), 1'b1, vecs[3].exp, 4'd8);
            drive(1'b0, 32'h0, 32'h0, 4'h0);
            ce  = (v == 0);
            rst = 1'b1;
            step();
            check($sformatf("rst%0d.valid", v),  {31'b0, bus.out_valid}, 32'h0);
            check($sformatf("rst%0d.result", v), bus.Result, 32'h0);
            check($sformatf("rst%0d.tag", v),    {28'b0, bus.out_tag}, 32'h0);
            rst = 1'b0;
            ce  = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step();
                check($sformatf("rst%0d_stale%0d", v, c), {31'b0, bus.out_valid}, 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
